// File: rtl/bcnn_pkg.sv
// bcnn_pkg: shared FSM encoding, tile constants and 4x4 tile extraction
package bcnn_pkg;
  typedef enum logic [2:0] {IDLE, HDR, HCAP, LOAD, EMIT, DONE} state_t;
  localparam int TILE_BITS = 16;
  localparam int KERNEL_BITS = 9;
  localparam int HDR_DIM_BITS = 5;
  localparam int MIN_DIM = 4;
  function automatic logic [TILE_BITS-1:0] extract_tile(input logic [3:0][15:0] rows, input logic [3:0] c0);
    logic [TILE_BITS-1:0] t;
    for (int i = 0; i < 4; i++) t[4*i +: 4] = 4'(rows[i] >> c0);
    return t;
  endfunction
endpackage

// File: rtl/bcnn_tile_fetcher_row_buffer.sv
// bcnn_row_buffer: four image rows with shift-by-two, indexed write and 4x4 tile extraction
module bcnn_row_buffer
  import bcnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 shift,
  input  logic                 wr_en,
  input  logic [1:0]           wr_idx,
  input  logic [15:0]          wr_data,
  input  logic [3:0]           c0,
  output logic [TILE_BITS-1:0] tile
);
  logic [3:0][15:0] rows_q, rows_d;
  always_comb begin
    rows_d = shift ? {16'h0, 16'h0, rows_q[3], rows_q[2]} : rows_q;
    if (wr_en) rows_d[wr_idx] = wr_data;
  end
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) rows_q <= '0;
    else rows_q <= rows_d;
  end
  assign tile = extract_tile(rows_q, c0);
endmodule

// File: rtl/bcnn_tile_fetcher.sv
// bcnn_tile_fetcher: loads header, kernel and image rows, streams stride-2 4x4 tiles
module bcnn_tile_fetcher
  import bcnn_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int MAX_DIM  = 16,
  parameter int IMG_BASE = 0,
  parameter int WGT_BASE = 0
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   dut_run,
  output logic                   busy,
  output logic                   err,
  output logic [ADDR_W-1:0]      sram_rd_addr,
  input  logic [DATA_W-1:0]      sram_rd_data,
  output logic [ADDR_W-1:0]      wmem_rd_addr,
  input  logic [DATA_W-1:0]      wmem_rd_data,
  output logic                   tile_valid,
  input  logic                   tile_ready,
  output logic [TILE_BITS-1:0]   tile_data,
  output logic [KERNEL_BITS-1:0] tile_weight,
  output logic [3:0]             tile_row,
  output logic [3:0]             tile_col,
  output logic                   tile_last
);
  state_t state_q, state_d;
  logic [HDR_DIM_BITS-1:0] n_q, n_d, hdr_n, last_pos;
  logic [KERNEL_BITS-1:0] kernel_q, kernel_d;
  logic [2:0] br_q, br_d, bc_q, bc_d, k_q, k_d, n_reads;
  logic err_q, err_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d, wmem_addr_q, wmem_addr_d;
  logic hdr_ok, first_band, row_end, xfer, shift, wr_en;
  logic [1:0] wr_idx;
  logic unused_wmem;
  assign unused_wmem = ^wmem_rd_data[DATA_W-1:KERNEL_BITS];
  assign hdr_n = sram_rd_data[HDR_DIM_BITS-1:0];
  assign hdr_ok = !hdr_n[0] && hdr_n >= HDR_DIM_BITS'(MIN_DIM) && hdr_n <= HDR_DIM_BITS'(MAX_DIM);
  assign last_pos = n_q - HDR_DIM_BITS'(MIN_DIM);
  assign first_band = br_q == 3'd0;
  assign n_reads = first_band ? 3'd4 : 3'd2;
  assign row_end = {1'b0, bc_q, 1'b0} == last_pos;
  assign tile_valid = state_q == EMIT;
  assign tile_last = tile_valid && row_end && {1'b0, br_q, 1'b0} == last_pos;
  assign xfer = tile_valid && tile_ready;
  assign shift = xfer && row_end && !tile_last;
  assign wr_en = state_q == LOAD && k_q != 3'd0;
  assign wr_idx = 2'(k_q - 3'd1) + (first_band ? 2'd0 : 2'd2);
  assign busy = state_q != IDLE;
  assign err = err_q;
  assign sram_rd_addr = sram_addr_q;
  assign wmem_rd_addr = wmem_addr_q;
  assign tile_weight = kernel_q;
  assign tile_row = {1'b0, br_q};
  assign tile_col = {1'b0, bc_q};
  bcnn_row_buffer u_rows (
    .clk     (clk),
    .reset_b (reset_b),
    .shift   (shift),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (sram_rd_data[15:0]),
    .c0      ({bc_q, 1'b0}),
    .tile    (tile_data)
  );
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    kernel_d = kernel_q;
    br_d = br_q;
    bc_d = bc_q;
    k_d = k_q;
    err_d = err_q;
    sram_addr_d = sram_addr_q;
    wmem_addr_d = wmem_addr_q;
    case (state_q)
      IDLE: if (dut_run) begin
        state_d = HDR;
        err_d = 1'b0;
        br_d = 3'd0;
        bc_d = 3'd0;
        sram_addr_d = ADDR_W'(IMG_BASE);
        wmem_addr_d = ADDR_W'(WGT_BASE);
      end
      HDR: state_d = HCAP;
      HCAP: begin
        n_d = hdr_n;
        kernel_d = wmem_rd_data[KERNEL_BITS-1:0];
        err_d = !hdr_ok;
        k_d = 3'd0;
        state_d = hdr_ok ? LOAD : DONE;
        sram_addr_d = hdr_ok ? ADDR_W'(IMG_BASE + 1) : sram_addr_q;
      end
      LOAD: begin
        k_d = k_q + 3'd1;
        state_d = k_q == n_reads ? EMIT : LOAD;
        sram_addr_d = k_q + 3'd1 < n_reads ? sram_addr_q + ADDR_W'(1) : sram_addr_q;
      end
      EMIT: if (xfer) begin
        if (tile_last) state_d = DONE;
        else if (row_end) begin
          state_d = LOAD;
          k_d = 3'd0;
          br_d = br_q + 3'd1;
          bc_d = 3'd0;
          sram_addr_d = ADDR_W'(IMG_BASE + 5) + ADDR_W'({br_q, 1'b0});
        end
        else bc_d = bc_q + 3'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      n_q <= '0;
      kernel_q <= '0;
      br_q <= '0;
      bc_q <= '0;
      k_q <= '0;
      err_q <= 1'b0;
      sram_addr_q <= '0;
      wmem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      kernel_q <= kernel_d;
      br_q <= br_d;
      bc_q <= bc_d;
      k_q <= k_d;
      err_q <= err_d;
      sram_addr_q <= sram_addr_d;
      wmem_addr_q <= wmem_addr_d;
    end
  end
endmodule

// File: doc/bcnn_tile_fetcher.md
Name: bcnn_tile_fetcher

Overview:
Upstream feeder for the binary 3x3 convolution stage. On dut_run it reads an image header and binary image rows from input SRAM, and one 9-bit kernel from weight memory. It then streams 4x4 binary tiles at stride 2, each with the kernel, to the convolution stage over a valid/ready handshake. Each tile yields one 2x2 convolution output block downstream.

Parameters:
ADDR_W, 12, SRAM and WMEM address width
DATA_W, 16, SRAM and WMEM word width; also the maximum image row width in bits
MAX_DIM, 16, largest legal image dimension N
IMG_BASE, 0, SRAM address of the header word; image row r sits at IMG_BASE+1+r
WGT_BASE, 0, WMEM address of the kernel word

Ports:
clk  in  1  clock
reset_b  in  1  asynchronous, active-low reset
dut_run  in  1  start pulse; sampled only in IDLE
busy  out  1  high from the cycle after dut_run is accepted until DONE is exited
err  out  1  sticky high when the header is illegal; cleared on the next accepted dut_run
sram_rd_addr  out  ADDR_W  registered SRAM read address
sram_rd_data  in  DATA_W  SRAM data, valid one cycle after the address is presented
wmem_rd_addr  out  ADDR_W  registered WMEM read address
wmem_rd_data  in  DATA_W  WMEM data, one-cycle latency
tile_valid  out  1  tile_data, tile_weight and the tag outputs are valid
tile_ready  in  1  consumer accepts the tile; transfer occurs when valid && ready
tile_data  out  16  bit 4*i+j = image[r0+i][c0+j], for i,j in 0..3
tile_weight  out  9  kernel bits [8:0]; bit 3*i+j = w[i][j]
tile_row  out  4  r0/2, output block row index
tile_col  out  4  c0/2, output block column index
tile_last  out  1  high with the final tile of the image

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, row buffer cleared.
- Header word: N = sram_rd_data[4:0]. N is legal only if it is even and 4 <= N <= MAX_DIM.
- Image row word: bit c = pixel column c. Bits at c >= N are ignored.
- Tile grid: T = (N-2)/2 tiles per dimension, r0 and c0 in {0, 2, ..., N-4}. Tiles are emitted row-major: c0 varies fastest.
- Row buffer: four 16-bit rows holding image rows r0..r0+3.
  - First band loads 4 rows.
  - Each later band shifts the buffer up by two rows and loads only rows r0+2 and r0+3.
- States:
  - IDLE: waits for dut_run. On dut_run: set busy=1, clear err, go to HDR.
  - HDR: drive sram_rd_addr=IMG_BASE and wmem_rd_addr=WGT_BASE. Next cycle is HCAP.
  - HCAP: latch N and the kernel (wmem_rd_data[8:0]). If N is illegal, set err=1 and go to DONE. Otherwise go to LOAD.
  - LOAD: issue row reads back-to-back, one per cycle; capture each one cycle after its address. After the last capture, go to EMIT.
  - EMIT: assert tile_valid.
    - On a transfer: advance c0.
    - At the end of a row (c0 = N-4): advance r0 and go to LOAD.
    - On the final tile (r0 = c0 = N-4): set tile_last=1; after its transfer, go to DONE.
  - DONE: one cycle with tile_valid=0, then busy=0 and return to IDLE.
- Handshake: while tile_valid && !tile_ready, all tile outputs hold stable. tile_valid never drops without a transfer except on reset. tile_ready while tile_valid=0 has no effect.
- Throughput: within a band, one tile per cycle when tile_ready is held high. A band change costs exactly 3 cycles with tile_valid low (2 reads plus capture).
- First tile: for N=4, tile_valid rises on the 8th rising edge after dut_run is sampled (HDR, HCAP, 4 reads, 1 capture lag, then EMIT).
- tile_weight is constant for the whole image.
- dut_run while busy=1 is ignored. dut_run in the same cycle that DONE returns to IDLE is not accepted.
- Read addresses hold their last value when not reading. Address arithmetic wraps modulo 2^ADDR_W.
- Asserting reset_b low mid-operation immediately clears all outputs and state. No partial tile is completed after reset releases.

Decomposition:
- Shared package bcnn_pkg:
  - FSM state encoding: IDLE, HDR, HCAP, LOAD, EMIT, DONE.
  - Constants TILE_BITS=16, KERNEL_BITS=9, HDR_DIM_BITS=5, MIN_DIM=4.
  - Function to extract a 4x4 tile from four rows at column c0, shared with the convolution-stage bench models.
- One sub-module is natural: bcnn_row_buffer. It holds four rows with a shift-by-two and write-by-index port, and performs the combinational 4x4 extraction at c0.

Test Plan:
1. N=4, rows 0x000F, 0x0009, 0x0009, 0x000F, kernel 0x1FF, tile_ready=1 -> exactly one tile: tile_data=0xF99F, tile_weight=0x1FF, tile_row=0, tile_col=0, tile_last=1. busy falls 2 cycles after the transfer.
2. N=6, row r = 0x3F ^ (1<<r) -> four tiles in order (0,0), (0,1), (1,0), (1,1). Each tile_data matches the reference extraction. Exactly 3 idle cycles between tiles (0,1) and (1,0). Only 6 row reads occur in total.
3. N=6 with tile_ready toggled 1,0,0,1 per cycle -> tile_data and tags hold stable during the stall. No tile is duplicated or dropped. 4 transfers total.
4. Header N=5, then N=18, then N=2 -> for each: err=1, zero tile_valid cycles, busy falls. A following legal run clears err.
5. dut_run pulsed again mid-EMIT on an N=8 image -> ignored; exactly 9 tiles produced, tile_last only on (2,2).
6. reset_b low during the second tile of N=6 -> all outputs 0 asynchronously. After release, dut_run restarts from the header and tile (0,0) is produced first.
